mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu_pkg.sv | 27 ++
 rtl/mdu.sv | 130 +++++++++++++
 tb/tb_mdu.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Brief    : MDUOp opcode encodings and helpers shared by the mult/div unit.
// Revision : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    // Two's-complement magnitude; 0x80000000 maps to 2^31 read as unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module   : mdu
// Brief    : E-stage multiply/divide unit with HI/LO, fixed-latency busy window.
// Revision : 1.0 - initial release
// ============================================================================
module mdu
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        Start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] MDUOut
);

    localparam int                 c_MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int                 c_CNT_W   = $clog2(c_MAX_LAT + 1);
    localparam logic [c_CNT_W-1:0] c_MUL_CNT = c_CNT_W'(MUL_LAT);
    localparam logic [c_CNT_W-1:0] c_DIV_CNT = c_CNT_W'(DIV_LAT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic [31:0]        r_hi, r_lo, r_thi, r_tlo;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_busy;
    logic               w_start_ok;
    logic [63:0]        w_prod_s, w_prod_u;
    logic [31:0]        w_a_mag, w_b_mag, w_bs_den, w_bu_den;
    logic [31:0]        w_qs_mag, w_rs_mag, w_q_s, w_r_s, w_q_u, w_r_u;
    logic [31:0]        w_res_hi, w_res_lo;
    logic [c_CNT_W-1:0] w_lat;

    assign w_busy = (r_cnt != '0);
    assign Busy   = w_busy;

    // Low 64 bits of the sign-extended product equal the signed 32x32 product.
    assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide via magnitudes, so INT_MIN / -1 wraps to 0x80000000.
    assign w_a_mag  = abs32(A);
    assign w_b_mag  = abs32(B);
    assign w_bs_den = (B == 32'd0) ? 32'd1 : w_b_mag;
    assign w_bu_den = (B == 32'd0) ? 32'd1 : B;
    assign w_qs_mag = w_a_mag / w_bs_den;
    assign w_rs_mag = w_a_mag % w_bs_den;
    assign w_q_s    = (A[31] ^ B[31]) ? (~w_qs_mag + 32'd1) : w_qs_mag;
    assign w_r_s    = A[31] ? (~w_rs_mag + 32'd1) : w_rs_mag;
    assign w_q_u    = A / w_bu_den;
    assign w_r_u    = A % w_bu_den;

    always_comb begin
        w_start_ok = 1'b0;
        w_res_hi   = r_hi;
        w_res_lo   = r_lo;
        w_lat      = c_MUL_CNT;
        case (MDUOp)
            MDU_MULT: begin
                w_start_ok = Start;
                {w_res_hi, w_res_lo} = w_prod_s;
            end
            MDU_MULTU: begin
                w_start_ok = Start;
                {w_res_hi, w_res_lo} = w_prod_u;
            end
            // A zero divisor buffers the current HI/LO, so the commit is a no-op.
            MDU_DIV: begin
                w_start_ok = Start;
                w_lat      = c_DIV_CNT;
                if (B != 32'd0) begin
                    w_res_hi = w_r_s;
                    w_res_lo = w_q_s;
                end
            end
            MDU_DIVU: begin
                w_start_ok = Start;
                w_lat      = c_DIV_CNT;
                if (B != 32'd0) begin
                    w_res_hi = w_r_u;
                    w_res_lo = w_q_u;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
            r_thi <= 32'd0;
            r_tlo <= 32'd0;
            r_cnt <= '0;
        end else if (w_busy) begin
            r_cnt <= r_cnt - c_CNT_ONE;
            if (r_cnt == c_CNT_ONE) begin
                r_hi <= r_thi;
                r_lo <= r_tlo;
            end
        end else if (!Req) begin
            if (w_start_ok) begin
                r_thi <= w_res_hi;
                r_tlo <= w_res_lo;
                r_cnt <= w_lat;
            end else if (MDUOp == MDU_MTHI) begin
                r_hi <= A;
            end else if (MDUOp == MDU_MTLO) begin
                r_lo <= A;
            end
        end
    end

    always_comb begin
        case (MDUOp)
            MDU_MFHI: MDUOut = r_hi;
            MDU_MFLO: MDUOut = r_lo;
            default:  MDUOut = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu
// Brief    : Self-checking bench for mdu against a cycle-level HI/LO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu;
    import mdu_pkg::*;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk = 1'b0;
    logic        reset, Req, Start;
    logic [3:0]  MDUOp;
    logic [31:0] A, B;
    logic        Busy;
    logic [31:0] MDUOut;

    int vectors = 0;
    int errors  = 0;

    // Reference state: committed HI/LO, cycles left busy, pending result.
    logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
    int          m_left = 0;
    bit          m_pend_ok = 0;

    mdu #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .Req(Req), .Start(Start), .MDUOp(MDUOp),
        .A(A), .B(B), .Busy(Busy), .MDUOut(MDUOut)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        sa = longint'($signed(A));
        sb = longint'($signed(B));
        ua = {32'd0, A};
        ub = {32'd0, B};
        if (reset) begin
            m_hi = 0; m_lo = 0; m_left = 0; m_pend_ok = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pend_ok) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (!Req) begin
            if (Start && MDUOp == MDU_MULT) begin
                sp = sa * sb;
                m_phi = sp[63:32]; m_plo = sp[31:0];
                m_pend_ok = 1; m_left = MUL_LAT;
            end else if (Start && MDUOp == MDU_MULTU) begin
                up = ua * ub;
                m_phi = up[63:32]; m_plo = up[31:0];
                m_pend_ok = 1; m_left = MUL_LAT;
            end else if (Start && MDUOp == MDU_DIV) begin
                m_pend_ok = (B != 0);
                if (B != 0) begin
                    sq = sa / sb; sr = sa % sb;
                    m_plo = sq[31:0]; m_phi = sr[31:0];
                end
                m_left = DIV_LAT;
            end else if (Start && MDUOp == MDU_DIVU) begin
                m_pend_ok = (B != 0);
                if (B != 0) begin
                    up = ua / ub; m_plo = up[31:0];
                    up = ua % ub; m_phi = up[31:0];
                end
                m_left = DIV_LAT;
            end else if (MDUOp == MDU_MTHI) begin
                m_hi = A;
            end else if (MDUOp == MDU_MTLO) begin
                m_lo = A;
            end
        end
    endtask

    task automatic idle();
        reset = 0; Req = 0; Start = 0; MDUOp = MDU_NONE; A = 0; B = 0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        idle();
        Start = (op >= MDU_MULT && op <= MDU_DIVU);
        MDUOp = op; A = a; B = b;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle(); reset = 1; tick(); tick(); idle();
        #1; vectors++;
        if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        MDUOp = MDU_MFHI; #1; vectors++;
        if (MDUOut !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", MDUOut); end
        MDUOp = MDU_MFLO; #1; vectors++;
        if (MDUOut !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", MDUOut); end
        idle();
    endtask

    task automatic test_mult();
        issue(MDU_MULT, 32'hFFFFFFFE, 32'd3);
        for (int k = 1; k <= MUL_LAT; k++) begin
            #1; vectors++;
            if (Busy !== 1'b1) begin errors++; $display("FAIL mult_busy T+%0d: got %b expected 1", k, Busy); end
            tick();
        end
        #1; vectors++;
        if (Busy !== 1'b0) begin errors++; $display("FAIL mult_done_busy: got %b expected 0", Busy); end
        MDUOp = MDU_MFHI; #1; vectors++;
        if (MDUOut !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", MDUOut); end
        MDUOp = MDU_MFLO; #1; vectors++;
        if (MDUOut !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo: got %h expected fffffffa", MDUOut); end
        idle();
        issue(MDU_MULTU, 32'hFFFFFFFF, 32'd2);
        repeat (MUL_LAT) tick();
        MDUOp = MDU_MFHI; #1; vectors++;
        if (MDUOut !== 32'h1) begin errors++; $display("FAIL multu_hi: got %h expected 00000001", MDUOut); end
        MDUOp = MDU_MFLO; #1; vectors++;
        if (MDUOut !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_lo: got %h expected fffffffe", MDUOut); end
        idle();
    endtask

    task automatic test_div();
        logic [31:0] exp_lo [3] = '{32'hFFFFFFFD, 32'h7FFFFFFC, 32'h80000000};
        logic [31:0] exp_hi [3] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        logic [3:0]  ops    [3] = '{MDU_DIV, MDU_DIVU, MDU_DIV};
        logic [31:0] as     [3] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000};
        logic [31:0] bs     [3] = '{32'd2, 32'd2, 32'hFFFFFFFF};
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], as[i], bs[i]);
            repeat (DIV_LAT - 1) tick();
            #1; vectors++;
            if (Busy !== 1'b1) begin errors++; $display("FAIL div%0d_last_busy: got %b expected 1", i, Busy); end
            tick();
            #1; vectors++;
            if (Busy !== 1'b0) begin errors++; $display("FAIL div%0d_done_busy: got %b expected 0", i, Busy); end
            MDUOp = MDU_MFLO; #1; vectors++;
            if (MDUOut !== exp_lo[i]) begin errors++; $display("FAIL div%0d_lo: got %h expected %h", i, MDUOut, exp_lo[i]); end
            MDUOp = MDU_MFHI; #1; vectors++;
            if (MDUOut !== exp_hi[i]) begin errors++; $display("FAIL div%0d_hi: got %h expected %h", i, MDUOut, exp_hi[i]); end
            idle();
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] lo_before;
        issue(MDU_MTHI, 32'h1234, 32'd0);
        lo_before = m_lo;
        MDUOp = MDU_MFHI; #1; vectors++;
        if (MDUOut !== 32'h1234) begin errors++; $display("FAIL mthi_next: got %h expected 00001234", MDUOut); end
        issue(MDU_DIV, 32'd5, 32'd0);
        for (int k = 1; k <= DIV_LAT + 1; k++) begin
            #1; vectors++;
            if (Busy !== (k <= DIV_LAT)) begin errors++; $display("FAIL div0_busy T+%0d: got %b expected %b", k, Busy, k <= DIV_LAT); end
            tick();
        end
        MDUOp = MDU_MFHI; #1; vectors++;
        if (MDUOut !== 32'h1234) begin errors++; $display("FAIL div0_hi: got %h expected 00001234", MDUOut); end
        MDUOp = MDU_MFLO; #1; vectors++;
        if (MDUOut !== lo_before) begin errors++; $display("FAIL div0_lo: got %h expected %h", MDUOut, lo_before); end
        idle();
    endtask

    task automatic test_req();
        issue(MDU_MTLO, 32'hCAFE0001, 32'd0);
        idle(); Req = 1; Start = 1; MDUOp = MDU_MULT; A = 32'd9; B = 32'd9; tick();
        idle(); Req = 1; MDUOp = MDU_MTLO; A = 32'h5; tick(); idle();
        #1; vectors++;
        if (Busy !== 1'b0) begin errors++; $display("FAIL req_start_busy: got %b expected 0", Busy); end
        MDUOp = MDU_MFLO; #1; vectors++;
        if (MDUOut !== 32'hCAFE0001) begin errors++; $display("FAIL req_lo_kept: got %h expected cafe0001", MDUOut); end
        issue(MDU_MULT, 32'd7, 32'd6);
        for (int k = 1; k <= MUL_LAT; k++) begin
            Req = (k == 3);
            tick();
        end
        idle();
        MDUOp = MDU_MFLO; #1; vectors++;
        if (MDUOut !== 32'd42) begin errors++; $display("FAIL req_mult_lo: got %h expected 0000002a", MDUOut); end
        MDUOp = MDU_MFHI; #1; vectors++;
        if (MDUOut !== 32'd0) begin errors++; $display("FAIL req_mult_hi: got %h expected 0", MDUOut); end
        idle();
    endtask

    task automatic test_reset_mid();
        issue(MDU_MTHI, 32'hAAAA5555, 32'd0);
        issue(MDU_DIV, 32'd100, 32'd7);
        tick(); tick();
        reset = 1; Start = 1; MDUOp = MDU_MTLO; A = 32'h77; tick(); idle();
        #1; vectors++;
        if (Busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", Busy); end
        MDUOp = MDU_MFHI; #1; vectors++;
        if (MDUOut !== 32'd0) begin errors++; $display("FAIL rstmid_hi: got %h expected 0", MDUOut); end
        idle();
        repeat (DIV_LAT) tick();
        MDUOp = MDU_MFLO; #1; vectors++;
        if (MDUOut !== 32'd0) begin errors++; $display("FAIL rstmid_no_commit: got %h expected 0", MDUOut); end
        idle();
    endtask

    task automatic test_back_to_back();
        issue(MDU_MTHI, 32'h00000BAD, 32'd0);
        issue(MDU_MULT, 32'h00010000, 32'h00010000);
        tick();
        Start = 1; MDUOp = MDU_DIV; A = 32'd9; B = 32'd2; tick(); idle();
        MDUOp = MDU_MTLO; A = 32'hDEAD; tick(); idle();
        MDUOp = MDU_MFHI; #1; vectors++;
        if (MDUOut !== 32'h00000BAD) begin errors++; $display("FAIL b2b_hi_before_commit: got %h expected 00000bad", MDUOut); end
        idle(); tick();
        #1; vectors++;
        if (Busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_T5: got %b expected 1", Busy); end
        tick();
        #1; vectors++;
        if (Busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_T6: got %b expected 0", Busy); end
        MDUOp = MDU_MFHI; #1; vectors++;
        if (MDUOut !== 32'h1) begin errors++; $display("FAIL b2b_hi: got %h expected 00000001", MDUOut); end
        MDUOp = MDU_MFLO; #1; vectors++;
        if (MDUOut !== 32'h0) begin errors++; $display("FAIL b2b_lo: got %h expected 0", MDUOut); end
        idle();
    endtask

    task automatic test_random();
        logic [31:0] exp_out;
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 79) == 0);
            Req   = ($urandom_range(0, 7) == 0);
            Start = ($urandom_range(0, 2) == 0);
            MDUOp = (Start && $urandom_range(0, 9) != 0) ? 4'($urandom_range(1, 4)) : 4'($urandom_range(0, 15));
            A = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       B = 32'd0;
                1:       B = 32'hFFFFFFFF;
                2:       B = 32'($urandom_range(1, 15));
                default: B = $urandom;
            endcase
            #1;
            exp_out = (MDUOp == MDU_MFHI) ? m_hi : (MDUOp == MDU_MFLO) ? m_lo : 32'd0;
            vectors++;
            if (Busy !== (m_left != 0)) begin errors++; $display("FAIL rand_busy #%0d: got %b expected %b", n, Busy, m_left != 0); end
            vectors++;
            if (MDUOut !== exp_out) begin errors++; $display("FAIL rand_out #%0d op=%0d: got %h expected %h", n, MDUOp, MDUOut, exp_out); end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        @(posedge clk); #1;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_req();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
